grey_to_rgb_colormap: RTL and testbench

//   Expands a single-channel grey/binary pixel stream back to 12-bit R/G/B for the VGA path.

---
 rtl/grey_to_rgb_colormap_if.sv | 36 +++
 rtl/grey_to_rgb_colormap.sv | 177 +++++++++++++++++
 tb/tb_grey_to_rgb_colormap.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/grey_to_rgb_colormap_if.sv
// Pixel stream bundle between the grey source and the colour-map stage.
// COLORMAP_STATS_EN adds the per-frame highlight count (oHI_CNT).
interface grey_to_rgb_colormap_if #(
  parameter int WIDTH = 12
);
  logic [WIDTH-1:0] iGREY;
  logic             iDVAL;
  logic             iFRAME_START;
  logic [1:0]       iMODE;
  logic [WIDTH-1:0] oRed;
  logic [WIDTH-1:0] oGreen;
  logic [WIDTH-1:0] oBlue;
  logic             oDVAL;
  logic [1:0]       oMODE;
`ifdef COLORMAP_STATS_EN
  logic [19:0]      oHI_CNT;

  modport master (
    output iGREY, iDVAL, iFRAME_START, iMODE,
    input  oRed, oGreen, oBlue, oDVAL, oMODE, oHI_CNT
  );
  modport slave (
    input  iGREY, iDVAL, iFRAME_START, iMODE,
    output oRed, oGreen, oBlue, oDVAL, oMODE, oHI_CNT
  );
`else
  modport master (
    output iGREY, iDVAL, iFRAME_START, iMODE,
    input  oRed, oGreen, oBlue, oDVAL, oMODE
  );
  modport slave (
    input  iGREY, iDVAL, iFRAME_START, iMODE,
    output oRed, oGreen, oBlue, oDVAL, oMODE
  );
`endif
endinterface

// File: rtl/grey_to_rgb_colormap.sv
// Grey to 12-bit RGB expansion, 3-stage pipeline, frame-latched colour-map mode.
// Optional COLORMAP_STATS_EN: per-frame count of pixels above THRESH on oHI_CNT.
module grey_to_rgb_colormap #(
  parameter int WIDTH  = 12,
  parameter int THRESH = 2000
) (
  input logic                  iCLK,
  input logic                  iRST,
  grey_to_rgb_colormap_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_GREY      = 2'b00,
    MODE_JET       = 2'b01,
    MODE_INVERT    = 2'b10,
    MODE_HIGHLIGHT = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] MAXV = '1;
  localparam logic [WIDTH-1:0] THR  = WIDTH'(THRESH);

  mode_e            modeQ;
  mode_e            effModeD;

  logic [WIDTH-1:0] greyS1Q;
  logic             dvalS1Q;
  mode_e            modeS1Q;

  logic [WIDTH-1:0] greyS2Q;
  logic [WIDTH-1:0] fracS2Q;
  logic [1:0]       segS2Q;
  logic             hiS2Q;
  logic             dvalS2Q;
  mode_e            modeS2Q;

  logic [WIDTH-1:0] redQ, greenQ, blueQ;
  logic [WIDTH-1:0] redD, greenD, blueD;
  logic             dvalS3Q;

  // A frame-start pixel already uses the newly requested mode.
  assign effModeD = bus.iFRAME_START ? mode_e'(bus.iMODE) : modeQ;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      modeQ   <= MODE_GREY;
      greyS1Q <= '0;
      dvalS1Q <= 1'b0;
      modeS1Q <= MODE_GREY;
    end else begin
      modeQ   <= effModeD;
      greyS1Q <= bus.iGREY;
      dvalS1Q <= bus.iDVAL;
      modeS1Q <= effModeD;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      greyS2Q <= '0;
      fracS2Q <= '0;
      segS2Q  <= '0;
      hiS2Q   <= 1'b0;
      dvalS2Q <= 1'b0;
      modeS2Q <= MODE_GREY;
    end else begin
      greyS2Q <= greyS1Q;
      fracS2Q <= {greyS1Q[WIDTH-3:0], greyS1Q[WIDTH-3:WIDTH-4]};
      segS2Q  <= greyS1Q[WIDTH-1:WIDTH-2];
      hiS2Q   <= (greyS1Q > THR);
      dvalS2Q <= dvalS1Q;
      modeS2Q <= modeS1Q;
    end
  end

  // Invalid slots leave the previous colour on the outputs.
  always_comb begin
    redD   = redQ;
    greenD = greenQ;
    blueD  = blueQ;
    if (dvalS2Q) begin
      case (modeS2Q)
        MODE_GREY: begin
          redD   = greyS2Q;
          greenD = greyS2Q;
          blueD  = greyS2Q;
        end
        MODE_INVERT: begin
          redD   = MAXV - greyS2Q;
          greenD = MAXV - greyS2Q;
          blueD  = MAXV - greyS2Q;
        end
        MODE_HIGHLIGHT: begin
          redD   = hiS2Q ? MAXV : greyS2Q;
          greenD = hiS2Q ? '0   : greyS2Q;
          blueD  = hiS2Q ? '0   : greyS2Q;
        end
        default: begin
          case (segS2Q)
            2'd0: begin
              redD   = '0;
              greenD = fracS2Q;
              blueD  = MAXV;
            end
            2'd1: begin
              redD   = '0;
              greenD = MAXV;
              blueD  = MAXV - fracS2Q;
            end
            2'd2: begin
              redD   = fracS2Q;
              greenD = MAXV;
              blueD  = '0;
            end
            default: begin
              redD   = MAXV;
              greenD = MAXV - fracS2Q;
              blueD  = '0;
            end
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      redQ    <= '0;
      greenQ  <= '0;
      blueQ   <= '0;
      dvalS3Q <= 1'b0;
    end else begin
      redQ    <= redD;
      greenQ  <= greenD;
      blueQ   <= blueD;
      dvalS3Q <= dvalS2Q;
    end
  end

  assign bus.oRed   = redQ;
  assign bus.oGreen = greenQ;
  assign bus.oBlue  = blueQ;
  assign bus.oDVAL  = dvalS3Q;
  assign bus.oMODE  = modeQ;

`ifdef COLORMAP_STATS_EN
  logic [19:0] cntQ, cntD;
  logic [19:0] hiCntQ, hiCntD;
  logic        qualifies;

  assign qualifies = bus.iDVAL && (bus.iGREY > THR);

  // Frame start publishes the finished count and seeds the next frame with its own pixel.
  always_comb begin
    cntD   = cntQ;
    hiCntD = hiCntQ;
    if (bus.iFRAME_START) begin
      hiCntD = cntQ;
      cntD   = qualifies ? 20'd1 : 20'd0;
    end else if (qualifies && (cntQ != 20'hFFFFF)) begin
      cntD = cntQ + 20'd1;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      cntQ   <= '0;
      hiCntQ <= '0;
    end else begin
      cntQ   <= cntD;
      hiCntQ <= hiCntD;
    end
  end

  assign bus.oHI_CNT = hiCntQ;
`endif

endmodule

// File: tb/tb_grey_to_rgb_colormap.sv
// Self-checking bench for grey_to_rgb_colormap: directed cases plus randomized
// traffic against a behavioural colour-map model.
module tb_grey_to_rgb_colormap;

  localparam int THRESH = 2000;

  typedef struct {
    bit          v;
    logic [35:0] rgb;
  } exp_t;

  logic iCLK = 1'b0;
  logic iRST;

  grey_to_rgb_colormap_if #(.WIDTH(12)) bus ();

  grey_to_rgb_colormap #(
    .WIDTH (12),
    .THRESH(THRESH)
  ) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .bus (bus.slave)
  );

  always #5 iCLK = ~iCLK;

  int          compared   = 0;
  int          mismatched = 0;
  exp_t        hist[$];
  logic [35:0] held;
  logic [1:0]  modelMode;
  int          modelCnt;
  int          modelHi;

  // Colour of one pixel straight from the colour-map rules.
  function automatic logic [35:0] refPixel(input int g, input int mode);
    int r, gr, b, seg, frac;
    r = g; gr = g; b = g;
    if (mode == 2) begin
      r = 4095 - g; gr = 4095 - g; b = 4095 - g;
    end else if (mode == 3) begin
      if (g > THRESH) begin
        r = 4095; gr = 0; b = 0;
      end
    end else if (mode == 1) begin
      seg  = g / 1024;
      frac = (g % 1024) * 4 + (g % 1024) / 256;
      if (seg == 0) begin
        r = 0; gr = frac; b = 4095;
      end else if (seg == 1) begin
        r = 0; gr = 4095; b = 4095 - frac;
      end else if (seg == 2) begin
        r = frac; gr = 4095; b = 0;
      end else begin
        r = 4095; gr = 4095 - frac; b = 0;
      end
    end
    return {12'(r), 12'(gr), 12'(b)};
  endfunction

  task automatic checkOutput(input string tag, input logic [35:0] obs, input logic [35:0] expv);
    compared++;
    if (obs !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic resetModel();
    exp_t e;
    e.v   = 1'b0;
    e.rgb = '0;
    hist.delete();
    hist.push_back(e);
    hist.push_back(e);
    held      = '0;
    modelMode = 2'b00;
    modelCnt  = 0;
    modelHi   = 0;
  endtask

  // Drive one pixel slot, advance one clock and compare everything observable.
  task automatic applyStimulus(input int g, input bit dv, input bit fs, input logic [1:0] mode);
    exp_t e, chk;
    bus.iGREY        = 12'(g);
    bus.iDVAL        = dv;
    bus.iFRAME_START = fs;
    bus.iMODE        = mode;
    if (fs) modelMode = mode;
    e.v   = dv;
    e.rgb = refPixel(g, int'(modelMode));
    hist.push_back(e);
    if (fs) begin
      modelHi  = modelCnt;
      modelCnt = (dv && g > THRESH) ? 1 : 0;
    end else if (dv && g > THRESH && modelCnt < 20'hFFFFF) begin
      modelCnt++;
    end
    @(posedge iCLK);
    #1;
    chk = hist.pop_front();
    if (chk.v) held = chk.rgb;
    checkOutput("dval", 36'(bus.oDVAL), 36'(chk.v));
    checkOutput("rgb", {bus.oRed, bus.oGreen, bus.oBlue}, held);
    checkOutput("mode", 36'(bus.oMODE), 36'(modelMode));
`ifdef COLORMAP_STATS_EN
    checkOutput("hicnt", 36'(bus.oHI_CNT), 36'(modelHi));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 1'b0, 1'b0, bus.iMODE);
  endtask

  initial begin
    bus.iGREY        = '0;
    bus.iDVAL        = 1'b0;
    bus.iFRAME_START = 1'b0;
    bus.iMODE        = 2'b00;
    iRST             = 1'b1;
    resetModel();
    repeat (3) @(posedge iCLK);
    #1;
    checkOutput("reset_rgb", {bus.oRed, bus.oGreen, bus.oBlue}, 36'h0);
    checkOutput("reset_dval", 36'(bus.oDVAL), 36'h0);
    checkOutput("reset_mode", 36'(bus.oMODE), 36'h0);
    @(negedge iCLK);
    iRST = 1'b0;

    // Replicate
    applyStimulus(12'h123, 1'b1, 1'b0, 2'b00);
    idle(2);
    checkOutput("replicate_123", {bus.oRed, bus.oGreen, bus.oBlue, 8'h0, 3'b0, bus.oDVAL},
                {36'h123123123, 11'h0, 1'b1});

    // Jet
    applyStimulus(12'h000, 1'b1, 1'b1, 2'b01);
    applyStimulus(12'h5FF, 1'b1, 1'b0, 2'b01);
    applyStimulus(12'hFFF, 1'b1, 1'b0, 2'b01);
    checkOutput("jet_000", {bus.oRed, bus.oGreen, bus.oBlue}, {12'd0, 12'd0, 12'd4095});
    applyStimulus(0, 1'b0, 1'b0, 2'b01);
    checkOutput("jet_5FF", {bus.oRed, bus.oGreen, bus.oBlue}, {12'd0, 12'd4095, 12'(4095 - 12'h7FD)});
    applyStimulus(0, 1'b0, 1'b0, 2'b01);
    checkOutput("jet_FFF", {bus.oRed, bus.oGreen, bus.oBlue}, {12'd4095, 12'd0, 12'd0});

    // Highlight threshold boundary
    applyStimulus(2000, 1'b1, 1'b1, 2'b11);
    applyStimulus(2001, 1'b1, 1'b0, 2'b11);
    idle(1);
    checkOutput("hl_2000", {bus.oRed, bus.oGreen, bus.oBlue}, {12'd2000, 12'd2000, 12'd2000});
    idle(1);
    checkOutput("hl_2001", {bus.oRed, bus.oGreen, bus.oBlue}, {12'd4095, 12'd0, 12'd0});

    // Mode request without frame start is ignored until the pulse
    applyStimulus(100, 1'b1, 1'b1, 2'b00);
    applyStimulus(100, 1'b1, 1'b0, 2'b10);
    applyStimulus(100, 1'b1, 1'b1, 2'b10);
    checkOutput("nofs_replicate", {bus.oRed, bus.oGreen, bus.oBlue}, {12'd100, 12'd100, 12'd100});
    applyStimulus(100, 1'b1, 1'b0, 2'b00);
    checkOutput("nofs_still_rep", {bus.oRed, bus.oGreen, bus.oBlue}, {12'd100, 12'd100, 12'd100});
    applyStimulus(0, 1'b0, 1'b0, 2'b00);
    checkOutput("fs_invert", {bus.oRed, bus.oGreen, bus.oBlue}, {12'd3995, 12'd3995, 12'd3995});

    // Valid gaps, then reset in the middle of the stream
    applyStimulus(10, 1'b1, 1'b0, 2'b00);
    applyStimulus(20, 1'b0, 1'b0, 2'b00);
    applyStimulus(30, 1'b1, 1'b0, 2'b00);
    applyStimulus(40, 1'b1, 1'b0, 2'b00);
    applyStimulus(50, 1'b1, 1'b0, 2'b00);
    iRST = 1'b1;
    #1;
    checkOutput("midrst_rgb", {bus.oRed, bus.oGreen, bus.oBlue}, 36'h0);
    checkOutput("midrst_dval", 36'(bus.oDVAL), 36'h0);
    checkOutput("midrst_mode", 36'(bus.oMODE), 36'h0);
    resetModel();
    @(negedge iCLK);
    iRST = 1'b0;
    idle(3);
    applyStimulus(7, 1'b1, 1'b0, 2'b11);
    idle(3);

`ifdef COLORMAP_STATS_EN
    applyStimulus(5, 1'b1, 1'b1, 2'b00);
    for (int i = 1; i < 10; i++) applyStimulus((i % 2 == 0 && i < 9) ? 3000 : 100, 1'b1, 1'b0, 2'b00);
    applyStimulus(5, 1'b1, 1'b1, 2'b00);
    checkOutput("hicnt_frame", 36'(bus.oHI_CNT), 36'd4);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int g;
      g = ($urandom_range(0, 3) == 0) ? $urandom_range(1990, 2010) : $urandom_range(0, 4095);
      applyStimulus(g, ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0),
                    2'($urandom_range(0, 3)));
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
